// File: rtl/instruction_memory_loader.sv
// Instruction memory loader: packs a valid/ready byte stream into big-endian
// 32-bit words and writes them to consecutive word addresses starting at 0,
// holding the CPU for the whole load and pulsing done at the end.
module instruction_memory_loader #(
  parameter int unsigned SIZE_EXP2 = 10
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIZE_EXP2:0]   word_count,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_write_enable,
  output logic [SIZE_EXP2-1:0] mem_address,
  output logic [31:0]          mem_data,
  output logic                 busy,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  // Largest legal load is exactly one full memory (2**SIZE_EXP2 words).
  localparam logic [SIZE_EXP2:0] MaxCount = {1'b1, {SIZE_EXP2{1'b0}}};
  localparam logic [SIZE_EXP2:0] OneCount = {{SIZE_EXP2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StReceive,
    StWrite,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [SIZE_EXP2-1:0] addr_q;
  logic [1:0]           idx_q;
  logic [31:0]          word_q;
  logic [SIZE_EXP2:0]   remaining_q;
  logic [SIZE_EXP2-1:0] mem_address_q;
  logic [31:0]          mem_data_q;
  logic                 byte_ready_q;
  logic                 error_q;

  logic                 start_ok;
  logic                 xfer;
  logic [31:0]          word_next;

  assign start_ok  = start && (word_count != '0) && (word_count <= MaxCount);
  assign xfer      = byte_valid && byte_ready_q;
  assign word_next = {word_q[23:0], byte_in};

  // State register.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && (word_count == '0)) begin
          state_d = StDone;
        end else if (start_ok) begin
          state_d = StReceive;
        end
      end
      StReceive: begin
        if (xfer && (idx_q == 2'd3)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = (remaining_q == OneCount) ? StDone : StReceive;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath: byte packing, address/count bookkeeping and registered strobes.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      addr_q        <= '0;
      idx_q         <= '0;
      word_q        <= '0;
      remaining_q   <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      byte_ready_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      byte_ready_q <= (state_d == StReceive);
      error_q      <= (state_q == StIdle) && start && (word_count > MaxCount);
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            remaining_q <= word_count;
            addr_q      <= '0;
            idx_q       <= '0;
          end
        end
        StReceive: begin
          if (xfer) begin
            word_q <= word_next;
            idx_q  <= idx_q + 2'd1;
            // Capture the completed word so the write port holds it after WRITE.
            if (idx_q == 2'd3) begin
              mem_address_q <= addr_q;
              mem_data_q    <= word_next;
            end
          end
        end
        StWrite: begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - OneCount;
          idx_q       <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy             = (state_q != StIdle);
  assign cpu_hold         = busy;
  assign done             = (state_q == StDone);
  assign mem_write_enable = (state_q == StWrite);
  assign mem_address      = mem_address_q;
  assign mem_data         = mem_data_q;
  assign byte_ready       = byte_ready_q;
  assign error            = error_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader.
module tb_instruction_memory_loader;

  logic        system_clock;
  logic        reset;
  logic        start;
  logic [10:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  instruction_memory_loader #(.SIZE_EXP2(10)) dut (
    .system_clock     (system_clock),
    .reset            (reset),
    .start            (start),
    .word_count       (word_count),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .busy             (busy),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem [1024];
  logic [7:0]  stream [4096];
  int          wr_count = 0;
  int          done_count = 0;
  int          br_bad = 0;
  int          last_addr = -1;

  // Write-port and handshake monitor, sampled mid-cycle.
  always @(negedge system_clock) begin
    if (mem_write_enable) begin
      tb_mem[mem_address] = mem_data;
      wr_count++;
      last_addr = int'(mem_address);
    end
    if (done) done_count++;
    if (byte_ready && (mem_write_enable || !busy || done)) br_bad++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Called at a negedge (cycle 0). Streams nw*4 bytes from `stream`, returns the
  // cycle index at which done was seen (-1 on timeout) and cycles without cpu_hold.
  task automatic do_load(input int nw, input logic [10:0] wc, input bit rnd,
                         input int restart_cyc, output int done_cyc, output int hold_bad);
    int bi;
    int cyc;
    bi = 0;
    cyc = 0;
    done_cyc = -1;
    hold_bad = 0;
    start = 1'b1;
    word_count = wc;
    byte_valid = 1'b0;
    while (cyc < 12000 && done_cyc < 0) begin
      @(negedge system_clock);
      cyc++;
      start = (cyc == restart_cyc);
      if (!cpu_hold) hold_bad++;
      if (done) done_cyc = cyc;
      if (bi < nw * 4) begin
        byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        byte_in = stream[bi];
        if (byte_valid && byte_ready) bi++;
      end else begin
        byte_valid = 1'b0;
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    int dc;
    int hb;
    int w0;
    int d0;
    int b0;
    logic [31:0] pattern [2];
    pattern[0] = 32'h2008_0005;
    pattern[1] = 32'h8C09_0004;
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    for (int i = 0; i < 1024; i++) tb_mem[i] = '0;

    // 1. Reset for 2 cycles.
    repeat (2) @(negedge system_clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd0);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    @(negedge system_clock);

    // 2. Two words, valid held high.
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 4; b++) stream[w*4+b] = pattern[w][31-8*b -: 8];
    w0 = wr_count; d0 = done_count;
    check("t2_hold_c0", 64'(cpu_hold), 64'd0);
    do_load(2, 11'd2, 1'b0, -1, dc, hb);
    check("t2_done_cyc", 64'(dc), 64'd11);
    check("t2_hold", 64'(hb), 64'd0);
    @(negedge system_clock);
    check("t2_hold_drop", 64'(cpu_hold), 64'd0);
    check("t2_busy_drop", 64'(busy), 64'd0);
    check("t2_writes", 64'(wr_count - w0), 64'd2);
    check("t2_dones", 64'(done_count - d0), 64'd1);
    check("t2_mem0", 64'(tb_mem[0]), 64'h2008_0005);
    check("t2_mem1", 64'(tb_mem[1]), 64'h8C09_0004);
    check("t2_hold_addr", 64'(mem_address), 64'd1);
    check("t2_hold_data", 64'(mem_data), 64'h8C09_0004);

    // 3. Same load with random valid gaps.
    tb_mem[0] = '0; tb_mem[1] = '0;
    w0 = wr_count; d0 = done_count; b0 = br_bad;
    do_load(2, 11'd2, 1'b1, -1, dc, hb);
    @(negedge system_clock);
    check("t3_done_seen", 64'(dc > 0), 64'd1);
    check("t3_hold", 64'(hb), 64'd0);
    check("t3_writes", 64'(wr_count - w0), 64'd2);
    check("t3_dones", 64'(done_count - d0), 64'd1);
    check("t3_mem0", 64'(tb_mem[0]), 64'h2008_0005);
    check("t3_mem1", 64'(tb_mem[1]), 64'h8C09_0004);
    check("t3_ready_scope", 64'(br_bad - b0), 64'd0);

    // 4. word_count = 0.
    w0 = wr_count;
    start = 1'b1; word_count = 11'd0;
    @(negedge system_clock);
    start = 1'b0;
    check("t4_done", 64'(done), 64'd1);
    check("t4_busy", 64'(busy), 64'd1);
    @(negedge system_clock);
    check("t4_done_end", 64'(done), 64'd0);
    check("t4_busy_end", 64'(busy), 64'd0);
    check("t4_writes", 64'(wr_count - w0), 64'd0);

    // 5. word_count = 1025 rejected.
    w0 = wr_count; d0 = done_count;
    start = 1'b1; word_count = 11'd1025;
    @(negedge system_clock);
    start = 1'b0;
    check("t5_error", 64'(error), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    @(negedge system_clock);
    check("t5_error_end", 64'(error), 64'd0);
    check("t5_busy_end", 64'(busy), 64'd0);
    check("t5_writes", 64'(wr_count - w0), 64'd0);
    check("t5_dones", 64'(done_count - d0), 64'd0);

    // 6. Reset mid-word, then load DEADBEEF with an ignored start while busy.
    w0 = wr_count; d0 = done_count;
    start = 1'b1; word_count = 11'd1;
    @(negedge system_clock);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'hAA;
    @(negedge system_clock);
    byte_in = 8'hBB;
    @(negedge system_clock);
    byte_valid = 1'b0; reset = 1'b1;
    @(negedge system_clock);
    reset = 1'b0;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_ready", 64'(byte_ready), 64'd0);
    stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE; stream[3] = 8'hEF;
    word_count = 11'd1;
    do_load(1, 11'd1, 1'b0, 3, dc, hb);
    check("t6_done_cyc", 64'(dc), 64'd6);
    @(negedge system_clock);
    check("t6_busy_end", 64'(busy), 64'd0);
    check("t6_writes", 64'(wr_count - w0), 64'd1);
    check("t6_dones", 64'(done_count - d0), 64'd1);
    check("t6_mem0", 64'(tb_mem[0]), 64'hDEAD_BEEF);
    check("t6_last_addr", 64'(last_addr), 64'd0);

    // 7. Full 1024-word load.
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] v;
      v = word_of(w);
      for (int b = 0; b < 4; b++) stream[w*4+b] = v[31-8*b -: 8];
    end
    w0 = wr_count; d0 = done_count;
    do_load(1024, 11'd1024, 1'b0, -1, dc, hb);
    check("t7_done_cyc", 64'(dc), 64'd5121);
    check("t7_hold", 64'(hb), 64'd0);
    @(negedge system_clock);
    check("t7_writes", 64'(wr_count - w0), 64'd1024);
    check("t7_dones", 64'(done_count - d0), 64'd1);
    check("t7_last_addr", 64'(last_addr), 64'd1023);
    check("t7_mem0", 64'(tb_mem[0]), 64'(word_of(0)));
    check("t7_mem517", 64'(tb_mem[517]), 64'(word_of(517)));
    check("t7_mem1023", 64'(tb_mem[1023]), 64'(word_of(1023)));
    check("t7_busy_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
